// File: rtl/rtc_bcd_counter.sv
// BCD seconds/minutes/hours timekeeper fed by a 1 Hz square wave sampled as data.
// Tick-to-output latency is SYNC_STAGES cycles; a load strobe always beats a tick.
module rtc_bcd_counter #(
  parameter int SYNC_STAGES = 2,
  parameter bit MODE_12H    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_1hz,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] set_time,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        min_wrap,
  output logic        hour_wrap,
  output logic        day_wrap,
  output logic        load_err
);

  localparam logic [23:0] RESET_TIME = MODE_12H ? 24'h120000 : 24'h000000;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Tracks which sync stages hold a real sample rather than the reset value.
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic        prev_q, prev_d;
  logic        armed_q, armed_d;
  logic [23:0] time_q, time_d;
  logic        sec_pulse_q, sec_pulse_d;
  logic        min_wrap_q, min_wrap_d;
  logic        hour_wrap_q, hour_wrap_d;
  logic        day_wrap_q, day_wrap_d;
  logic        load_err_q, load_err_d;

  logic        sync_last, fill_last, tick;
  logic [3:0]  h_t, h_u, m_t, m_u, s_t, s_u;
  logic [23:0] inc_time;
  logic        s_wrap, m_wrap, h_wrap;

  assign {h_t, h_u, m_t, m_u, s_t, s_u} = time_q;

  function automatic logic time_ok(input logic [23:0] t);
    logic digits_ok, hours_ok;
    digits_ok = (t[23:20] <= 4'd9) && (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) &&
                (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    if (MODE_12H)
      hours_ok = ((t[23:20] == 4'd0) && (t[19:16] != 4'd0)) ||
                 ((t[23:20] == 4'd1) && (t[19:16] <= 4'd2));
    else
      hours_ok = (t[23:20] < 4'd2) || ((t[23:20] == 4'd2) && (t[19:16] <= 4'd3));
    return digits_ok && hours_ok;
  endfunction

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], clk_1hz};
    fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sync_last = sync_q[SYNC_STAGES-1];
    fill_last = fill_q[SYNC_STAGES-1];
    prev_d    = sync_last;
    armed_d   = armed_q | (fill_last & ~sync_last);
    tick      = sync_last & ~prev_q & armed_q;
  end

  // One-second increment with BCD carries through all six digits.
  always_comb begin
    inc_time = time_q;
    s_wrap   = 1'b0;
    m_wrap   = 1'b0;
    h_wrap   = 1'b0;
    if (s_u != 4'd9) begin
      inc_time[3:0] = s_u + 4'd1;
    end else begin
      inc_time[3:0] = 4'd0;
      if (s_t != 4'd5) begin
        inc_time[7:4] = s_t + 4'd1;
      end else begin
        inc_time[7:4] = 4'd0;
        s_wrap = 1'b1;
        if (m_u != 4'd9) begin
          inc_time[11:8] = m_u + 4'd1;
        end else begin
          inc_time[11:8] = 4'd0;
          if (m_t != 4'd5) begin
            inc_time[15:12] = m_t + 4'd1;
          end else begin
            inc_time[15:12] = 4'd0;
            m_wrap = 1'b1;
            if (MODE_12H ? (time_q[23:16] == 8'h12) : (time_q[23:16] == 8'h23)) begin
              inc_time[23:16] = MODE_12H ? 8'h01 : 8'h00;
              h_wrap = 1'b1;
            end else if (h_u == 4'd9) begin
              inc_time[23:16] = {h_t + 4'd1, 4'd0};
            end else begin
              inc_time[19:16] = h_u + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    time_d      = time_q;
    load_err_d  = load_err_q;
    sec_pulse_d = 1'b0;
    min_wrap_d  = 1'b0;
    hour_wrap_d = 1'b0;
    day_wrap_d  = 1'b0;
    if (load) begin
      if (time_ok(set_time)) begin
        time_d     = set_time;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick && run) begin
      time_d      = inc_time;
      sec_pulse_d = 1'b1;
      min_wrap_d  = s_wrap;
      hour_wrap_d = m_wrap;
      day_wrap_d  = h_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      fill_q      <= '0;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      time_q      <= RESET_TIME;
      sec_pulse_q <= 1'b0;
      min_wrap_q  <= 1'b0;
      hour_wrap_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      time_q      <= time_d;
      sec_pulse_q <= sec_pulse_d;
      min_wrap_q  <= min_wrap_d;
      hour_wrap_q <= hour_wrap_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign time_bcd  = time_q;
  assign sec_pulse = sec_pulse_q;
  assign min_wrap  = min_wrap_q;
  assign hour_wrap = hour_wrap_q;
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Scoreboard bench: a 24-hour and a 12-hour instance, expected events queued by stimulus.
module tb_rtc_bcd_counter;

  typedef struct packed {
    logic [23:0] t;
    logic [3:0]  p;   // {sec, min, hour, day}
    logic        e;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b1;
  logic        c1_a = 1'b1, c1_b = 1'b0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic [23:0] set_a = '0, set_b = '0;
  logic [23:0] time_a, time_b;
  logic        sec_a, min_a, hour_a, day_a, err_a;
  logic        sec_b, min_b, hour_b, day_b, err_b;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  obs_t q_a[$], q_b[$];
  obs_t last_a, last_b, mdl_a, mdl_b;

  always #5 clk = ~clk;

  rtc_bcd_counter #(.SYNC_STAGES(2), .MODE_12H(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_1hz(c1_a), .run(run), .load(load_a), .set_time(set_a),
    .time_bcd(time_a), .sec_pulse(sec_a), .min_wrap(min_a), .hour_wrap(hour_a),
    .day_wrap(day_a), .load_err(err_a));

  rtc_bcd_counter #(.SYNC_STAGES(2), .MODE_12H(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_1hz(c1_b), .run(run), .load(load_b), .set_time(set_b),
    .time_bcd(time_b), .sec_pulse(sec_b), .min_wrap(min_b), .hour_wrap(hour_b),
    .day_wrap(day_b), .load_err(err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // An output event is any pulse or any change of time/error flag.
  task automatic mon_step();
    obs_t oa, ob, ex;
    oa = '{t: time_a, p: {sec_a, min_a, hour_a, day_a}, e: err_a};
    ob = '{t: time_b, p: {sec_b, min_b, hour_b, day_b}, e: err_b};
    if (oa.p != 4'b0 || oa.t != last_a.t || oa.e != last_a.e) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL mon_a_unexpected: got %h expected no event", oa);
      end else begin
        ex = q_a.pop_front();
        if (ex !== oa) begin
          failures++;
          $display("FAIL mon_a: got %h expected %h", oa, ex);
        end
      end
    end
    if (ob.p != 4'b0 || ob.t != last_b.t || ob.e != last_b.e) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL mon_b_unexpected: got %h expected no event", ob);
      end else begin
        ex = q_b.pop_front();
        if (ex !== ob) begin
          failures++;
          $display("FAIL mon_b: got %h expected %h", ob, ex);
        end
      end
    end
    last_a = oa;
    last_b = ob;
  endtask

  task automatic expect_a(input logic [23:0] t, input logic [3:0] p, input logic e);
    obs_t n;
    n = '{t: t, p: p, e: e};
    if (p != 4'b0 || t != mdl_a.t || e != mdl_a.e) q_a.push_back(n);
    mdl_a = n;
  endtask

  task automatic expect_b(input logic [23:0] t, input logic [3:0] p, input logic e);
    obs_t n;
    n = '{t: t, p: p, e: e};
    if (p != 4'b0 || t != mdl_b.t || e != mdl_b.e) q_b.push_back(n);
    mdl_b = n;
  endtask

  task automatic tick_a(input logic [23:0] t, input logic [3:0] p);
    expect_a(t, p, mdl_a.e);
    c1_a = 1'b1;
    repeat (4) @(negedge clk);
    c1_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_b(input logic [23:0] t, input logic [3:0] p);
    expect_b(t, p, mdl_b.e);
    c1_b = 1'b1;
    repeat (4) @(negedge clk);
    c1_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_vec_a(input logic [23:0] s, input logic [23:0] t, input logic e);
    expect_a(t, 4'b0, e);
    load_a = 1'b1;
    set_a  = s;
    @(negedge clk);
    load_a = 1'b0;
    chk("load_a_time", {8'h0, time_a}, {8'h0, t});
    chk("load_a_err", {31'h0, err_a}, {31'h0, e});
    repeat (2) @(negedge clk);
  endtask

  task automatic load_vec_b(input logic [23:0] s, input logic [23:0] t, input logic e);
    expect_b(t, 4'b0, e);
    load_b = 1'b1;
    set_b  = s;
    @(negedge clk);
    load_b = 1'b0;
    chk("load_b_time", {8'h0, time_b}, {8'h0, t});
    chk("load_b_err", {31'h0, err_b}, {31'h0, e});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      begin
        // 1 Hz input held high across reset release
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_a_time", {8'h0, time_a}, 32'h0);
        chk("reset_a_flags", {27'h0, sec_a, min_a, hour_a, day_a, err_a}, 32'h0);
        chk("reset_b_time", {8'h0, time_b}, 32'h00120000);
        chk("reset_b_flags", {27'h0, sec_b, min_b, hour_b, day_b, err_b}, 32'h0);
        mdl_a  = '{t: 24'h000000, p: 4'b0, e: 1'b0};
        mdl_b  = '{t: 24'h120000, p: 4'b0, e: 1'b0};
        last_a = mdl_a;
        last_b = mdl_b;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_spurious_tick", {8'h0, time_a}, 32'h0);
        c1_a = 1'b0;
        repeat (4) @(negedge clk);

        // first real tick: update lands exactly two posedges after the high sample
        expect_a(24'h000001, 4'b1000, 1'b0);
        c1_a = 1'b1;
        @(negedge clk);
        chk("lat_edge1", {8'h0, time_a}, 32'h0);
        @(negedge clk);
        chk("lat_edge2", {8'h0, time_a}, 32'h0);
        @(negedge clk);
        chk("lat_edge3_time", {8'h0, time_a}, 32'h1);
        chk("lat_edge3_pulse", {31'h0, sec_a}, 32'h1);
        @(negedge clk);
        chk("pulse_one_cycle", {31'h0, sec_a}, 32'h0);
        c1_a = 1'b0;
        repeat (4) @(negedge clk);

        // midnight rollover
        load_vec_a(24'h235958, 24'h235958, 1'b0);
        tick_a(24'h235959, 4'b1000);
        tick_a(24'h000000, 4'b1111);

        // invalid then valid loads
        load_vec_a(24'h0A0000, 24'h000000, 1'b1);
        load_vec_a(24'h006000, 24'h000000, 1'b1);
        load_vec_a(24'h240000, 24'h000000, 1'b1);
        load_vec_a(24'h101010, 24'h101010, 1'b0);

        // paused ticks are dropped, no catch-up
        load_vec_a(24'h000010, 24'h000010, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) tick_a(24'h000010, 4'b0000);
        chk("paused_time", {8'h0, time_a}, 32'h00000010);
        run = 1'b1;
        tick_a(24'h000011, 4'b1000);

        // load lands in the tick cycle: load wins, no pulse
        expect_a(24'h050000, 4'b0000, 1'b0);
        c1_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_a = 1'b1;
        set_a  = 24'h050000;
        @(negedge clk);
        load_a = 1'b0;
        chk("load_tick_time", {8'h0, time_a}, 32'h00050000);
        chk("load_tick_pulse", {31'h0, sec_a}, 32'h0);
        @(negedge clk);
        c1_a = 1'b0;
        repeat (4) @(negedge clk);
        tick_a(24'h050001, 4'b1000);

        // 12-hour instance
        load_vec_b(24'h125959, 24'h125959, 1'b0);
        tick_b(24'h010000, 4'b1111);
        load_vec_b(24'h000000, 24'h010000, 1'b1);
        load_vec_b(24'h095959, 24'h095959, 1'b0);
        tick_b(24'h100000, 4'b1110);
        load_vec_b(24'h130000, 24'h100000, 1'b1);

        repeat (6) @(negedge clk);
        chk("queue_a_drained", q_a.size(), 32'h0);
        chk("queue_b_drained", q_b.size(), 32'h0);
      end
      begin
        forever begin
          @(negedge clk);
          if (mon_en) mon_step();
        end
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
